// File: rtl/rf_wr_decoder.sv
// rtl/rf_wr_decoder.sv - multi-port register-file write-enable decoder with collision hold
//
// Purpose:
//   Decodes NPORTS binary write addresses into registered one-hot write
//   enables for the register file. Register 0 is hardwired zero, so its
//   writes produce no enable. When two ports target the same non-zero
//   register in one cycle, the lower-index port issues and the others are
//   parked in a per-port hold entry. The hold entries are then drained over
//   the following cycles while wr_ready_o stalls new requests.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   wr_valid_i     per-port write request
//   wr_addr_i      packed per-port addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_ready_o     global accept; a port is taken when valid & ready
//   we_onehot_o    registered per-port one-hot enables, port p at [p*NREG +: NREG]
//   we_any_o       registered OR of all per-port enables
//   conflict_o     one-cycle pulse after an accepted set produced a loser
//   conflict_cnt_o saturating count of conflict events
module rf_wr_decoder #(
   parameter int ADDR_W    = 5,
   parameter int NREG      = 1 << ADDR_W,
   parameter int NPORTS    = 2,
   parameter bit ZERO_MASK = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS-1:0]        wr_valid_i,
   input  logic [NPORTS*ADDR_W-1:0] wr_addr_i,
   output logic                     wr_ready_o,
   output logic [NPORTS*NREG-1:0]   we_onehot_o,
   output logic [NREG-1:0]          we_any_o,
   output logic                     conflict_o,
   output logic [CNT_W-1:0]         conflict_cnt_o
);

   // Per-port hold entries for requests that lost arbitration.
   logic [NPORTS-1:0] hold_v;
   logic [ADDR_W-1:0] hold_a [NPORTS];

   logic                   draining;
   logic [NPORTS-1:0]      cand_v;
   logic [ADDR_W-1:0]      cand_a [NPORTS];
   logic [NPORTS-1:0]      blocked;
   logic [NPORTS-1:0]      issue;
   logic [NPORTS-1:0]      lose;
   logic [NPORTS*NREG-1:0] onehot_d;
   logic [NREG-1:0]        any_d;
   logic                   conflict_d;

   assign draining   = |hold_v;
   // New requests are only taken when nothing is parked in the hold.
   assign wr_ready_o = ~rst & ~draining;

   // Candidate selection: the hold entries when draining, else accepted inputs.
   always_comb begin
      cand_v = '0;
      for (int p = 0; p < NPORTS; p++) begin
         cand_a[p] = '0;
         if (draining) begin
            cand_v[p] = hold_v[p];
            cand_a[p] = hold_a[p];
         end else begin
            cand_v[p] = wr_valid_i[p] & wr_ready_o;
            cand_a[p] = wr_addr_i[p*ADDR_W +: ADDR_W];
         end
      end
   end

   // A port is blocked by any lower-index candidate on the same non-zero
   // address; address 0 never collides since it writes nothing.
   always_comb begin
      blocked = '0;
      for (int p = 0; p < NPORTS; p++) begin
         for (int q = 0; q < NPORTS; q++) begin
            if (q < p && cand_v[q] && cand_v[p] &&
                cand_a[q] == cand_a[p] && cand_a[p] != '0) begin
               blocked[p] = 1'b1;
            end
         end
      end
   end

   assign issue      = cand_v & ~blocked;
   assign lose       = cand_v & blocked;
   // Only collisions among freshly accepted requests count as events.
   assign conflict_d = ~draining & (|lose);

   always_comb begin
      onehot_d = '0;
      any_d    = '0;
      for (int p = 0; p < NPORTS; p++) begin
         if (issue[p] && !(ZERO_MASK && cand_a[p] == '0)) begin
            onehot_d[p*NREG +: NREG] = NREG'(1) << cand_a[p];
         end
         any_d = any_d | onehot_d[p*NREG +: NREG];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_onehot_o    <= '0;
         we_any_o       <= '0;
         conflict_o     <= 1'b0;
         conflict_cnt_o <= '0;
         hold_v         <= '0;
         for (int p = 0; p < NPORTS; p++) begin
            hold_a[p] <= '0;
         end
      end else begin
         we_onehot_o <= onehot_d;
         we_any_o    <= any_d;
         conflict_o  <= conflict_d;
         if (conflict_d && conflict_cnt_o != {CNT_W{1'b1}}) begin
            conflict_cnt_o <= conflict_cnt_o + 1'b1;
         end
         // Winners leave the hold, losers (new or re-collided) stay parked.
         hold_v <= lose;
         for (int p = 0; p < NPORTS; p++) begin
            if (lose[p]) begin
               hold_a[p] <= cand_a[p];
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_wr_decoder.sv
// tb/tb_rf_wr_decoder.sv - randomized and directed bench for rf_wr_decoder
module tb_rf_wr_decoder;

   localparam int NP = 2;
   localparam int AW = 5;
   localparam int NR = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [NP-1:0]   wr_valid;
   logic [NP*AW-1:0] wr_addr;
   logic            ready;
   logic [NP*NR-1:0] oh;
   logic [NR-1:0]   any;
   logic            conf;
   logic [7:0]      cnt;
   logic            ready2;
   logic [NP*NR-1:0] oh2;
   logic [NR-1:0]   any2;
   logic            conf2;
   logic [1:0]      cnt2;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_cnt  = 0;
   int exp_cnt2 = 0;

   always #5 clk = ~clk;

   rf_wr_decoder #(.ADDR_W(AW), .NREG(NR), .NPORTS(NP), .ZERO_MASK(1'b1), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
      .wr_ready_o(ready), .we_onehot_o(oh), .we_any_o(any),
      .conflict_o(conf), .conflict_cnt_o(cnt)
   );

   rf_wr_decoder #(.ADDR_W(AW), .NREG(NR), .NPORTS(NP), .ZERO_MASK(1'b1), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
      .wr_ready_o(ready2), .we_onehot_o(oh2), .we_any_o(any2),
      .conflict_o(conf2), .conflict_cnt_o(cnt2)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Model: a port accepted in cycle N issues in cycle N+1+k, where k is the
   // number of lower-index accepted ports sharing its non-zero address.
   // Ready is low until the last of those issue slots.
   task automatic do_txn(input logic [NP-1:0] v, input logic [NP*AW-1:0] a, input string name);
      int k [NP];
      int maxk;
      logic [AW-1:0] ap;
      logic [AW-1:0] aq;
      logic [NP*NR-1:0] eoh;
      logic [NR-1:0] eany;
      logic econf;
      logic eready;
      maxk = 0;
      for (int p = 0; p < NP; p++) begin
         k[p] = 0;
         ap = a[p*AW +: AW];
         for (int q = 0; q < p; q++) begin
            aq = a[q*AW +: AW];
            if (v[p] && v[q] && ap == aq && ap != 0) k[p]++;
         end
         if (k[p] > maxk) maxk = k[p];
      end
      n_chk++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s pre_ready: got %b expected 1", name, ready);
      end
      wr_valid = v;
      wr_addr  = a;
      step();
      if (maxk > 0) begin
         if (exp_cnt < 255) exp_cnt++;
         if (exp_cnt2 < 3) exp_cnt2++;
      end
      for (int c = 0; c <= maxk; c++) begin
         eoh = '0;
         for (int p = 0; p < NP; p++) begin
            ap = a[p*AW +: AW];
            if (v[p] && k[p] == c && ap != 0) eoh[p*NR + int'(ap)] = 1'b1;
         end
         eany = '0;
         for (int p = 0; p < NP; p++) eany = eany | eoh[p*NR +: NR];
         econf  = (c == 0) && (maxk > 0);
         eready = (c == maxk);
         // Garbage while stalled must be ignored.
         if (c < maxk) begin
            wr_valid = NP'($urandom);
            wr_addr  = (NP*AW)'($urandom);
         end else begin
            wr_valid = '0;
            wr_addr  = '0;
         end
         n_chk++;
         if (oh !== eoh) begin
            n_fail++;
            $display("FAIL %s onehot c=%0d: got %h expected %h", name, c, oh, eoh);
         end
         n_chk++;
         if (any !== eany) begin
            n_fail++;
            $display("FAIL %s any c=%0d: got %h expected %h", name, c, any, eany);
         end
         n_chk++;
         if (conf !== econf) begin
            n_fail++;
            $display("FAIL %s conflict c=%0d: got %b expected %b", name, c, conf, econf);
         end
         n_chk++;
         if (ready !== eready) begin
            n_fail++;
            $display("FAIL %s ready c=%0d: got %b expected %b", name, c, ready, eready);
         end
         n_chk++;
         if (cnt !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s cnt: got %0d expected %0d", name, cnt, exp_cnt);
         end
         n_chk++;
         if (cnt2 !== 2'(exp_cnt2) || oh2 !== eoh) begin
            n_fail++;
            $display("FAIL %s dut2 cnt/onehot: got %0d/%h expected %0d/%h", name, cnt2, oh2, exp_cnt2, eoh);
         end
         step();
      end
      n_chk++;
      if (oh !== '0 || any !== '0 || conf !== 1'b0 || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s trailing: got oh=%h any=%h conf=%b rdy=%b expected zeros rdy=1",
                  name, oh, any, conf, ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wr_valid = '0;
      wr_addr  = '0;
      step();
      step();
      n_chk++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_low: got %b expected 0", ready);
      end
      n_chk++;
      if (oh !== '0 || any !== '0 || conf !== 1'b0 || cnt !== 8'd0 || cnt2 !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got oh=%h any=%h conf=%b cnt=%0d expected all 0", oh, any, conf, cnt);
      end
      rst = 1'b0;
      exp_cnt  = 0;
      exp_cnt2 = 0;
      #1;
      n_chk++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_release: got %b expected 1", ready);
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      do_txn(2'b01, {5'd0, 5'd3}, "single_addr3");
      do_txn(2'b01, {5'd0, 5'd0}, "zero_addr");
      do_txn(2'b11, {5'd1, 5'd31}, "distinct_31_1");
      do_txn(2'b10, {5'd9, 5'd9}, "p1_only");
      do_txn(2'b11, {5'd0, 5'd0}, "both_zero");
   endtask

   task automatic test_collision();
      wr_valid = 2'b11;
      wr_addr  = {5'd7, 5'd7};
      step();
      wr_valid = '0;
      wr_addr  = '0;
      exp_cnt++;
      exp_cnt2++;
      n_chk++;
      if (oh !== 64'h0000_0000_0000_0080 || conf !== 1'b1 || ready !== 1'b0 || cnt !== 8'(exp_cnt)) begin
         n_fail++;
         $display("FAIL coll_first: got oh=%h conf=%b rdy=%b cnt=%0d expected 80 1 0 %0d",
                  oh, conf, ready, cnt, exp_cnt);
      end
      step();
      n_chk++;
      if (oh !== 64'h0000_0080_0000_0000 || conf !== 1'b0 || ready !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_drain: got oh=%h conf=%b rdy=%b expected p1=80 0 1", oh, conf, ready);
      end
      step();
      n_chk++;
      if (oh !== '0) begin
         n_fail++;
         $display("FAIL coll_no_repeat: got %h expected 0", oh);
      end
   endtask

   task automatic test_reset_mid_drain();
      wr_valid = 2'b11;
      wr_addr  = {5'd7, 5'd7};
      step();
      wr_valid = '0;
      wr_addr  = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_cnt  = 0;
      exp_cnt2 = 0;
      n_chk++;
      if (oh !== '0 || cnt !== 8'd0 || conf !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_drain_flush: got oh=%h cnt=%0d conf=%b expected 0 0 0", oh, cnt, conf);
      end
      #1;
      n_chk++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_drain_ready: got %b expected 1", ready);
      end
      @(negedge clk);
      step();
      n_chk++;
      if (oh !== '0 || any !== '0) begin
         n_fail++;
         $display("FAIL rst_drain_no_issue: got %h expected 0", oh);
      end
   endtask

   task automatic test_saturation();
      test_reset();
      for (int i = 0; i < 4; i++) begin
         do_txn(2'b11, {5'd12, 5'd12}, "sat_collision");
      end
      n_chk++;
      if (cnt2 !== 2'd3 || cnt !== 8'd4) begin
         n_fail++;
         $display("FAIL saturation: got cnt2=%0d cnt=%0d expected 3 4", cnt2, cnt);
      end
   endtask

   task automatic test_random();
      logic [NP-1:0] v;
      logic [NP*AW-1:0] a;
      for (int i = 0; i < 60; i++) begin
         v = NP'($urandom_range(0, 3));
         for (int p = 0; p < NP; p++) begin
            if (i % 2 == 0) a[p*AW +: AW] = AW'($urandom_range(0, 2));
            else            a[p*AW +: AW] = AW'($urandom);
         end
         do_txn(v, a, "random");
      end
   endtask

   initial begin
      rst = 1'b1;
      wr_valid = '0;
      wr_addr  = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_collision();
      test_reset_mid_drain();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
